// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU reservation station with age-ordered oldest-ready select and dual-lane wakeup
module alu_rs #(
   parameter int DEPTH = 8,
   parameter int PRW   = 7
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        disp_valid,
   output logic                        disp_ready,
   input  logic [6:0]                  disp_opcode,
   input  logic [PRW-1:0]              disp_prd,
   input  logic [PRW-1:0]              disp_pr1,
   input  logic                        disp_pr1_ready,
   input  logic [PRW-1:0]              disp_pr2,
   input  logic                        disp_pr2_ready,
   input  logic [31:0]                 disp_imm,
   input  logic [3:0]                  disp_rob_index,
   input  logic [1:0]                  wb_valid,
   input  logic [2*PRW-1:0]            wb_tag,
   output logic                        iss_valid,
   input  logic                        iss_ready,
   output logic [6:0]                  iss_opcode,
   output logic [PRW-1:0]              iss_prd,
   output logic [PRW-1:0]              iss_pr1,
   output logic [PRW-1:0]              iss_pr2,
   output logic [31:0]                 iss_imm,
   output logic [3:0]                  iss_rob_index,
   input  logic                        flush,
   output logic [$clog2(DEPTH):0]      occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

   logic [DEPTH-1:0] e_valid;
   logic [DEPTH-1:0] e_rdy1;
   logic [DEPTH-1:0] e_rdy2;
   logic [6:0]       e_opcode [DEPTH];
   logic [PRW-1:0]   e_prd    [DEPTH];
   logic [PRW-1:0]   e_pr1    [DEPTH];
   logic [PRW-1:0]   e_pr2    [DEPTH];
   logic [31:0]      e_imm    [DEPTH];
   logic [3:0]       e_rob    [DEPTH];
   logic [AW-1:0]    e_age    [DEPTH];
   logic [OW-1:0]    occ;

   logic [PRW-1:0]   wb_tag0;
   logic [PRW-1:0]   wb_tag1;
   logic [DEPTH-1:0] hit1;
   logic [DEPTH-1:0] hit2;
   logic             disp_hit1;
   logic             disp_hit2;

   logic             sel_found;
   logic [AW-1:0]    sel_idx;
   logic [AW-1:0]    sel_age;
   logic [AW-1:0]    free_idx;
   logic             alloc;
   logic             iss_fire;
   logic [AW-1:0]    new_age;

   assign wb_tag0 = wb_tag[0 +: PRW];
   assign wb_tag1 = wb_tag[PRW +: PRW];

   // Readiness depends only on the registered count, never on this cycle's issue.
   assign disp_ready = (occ < FULL_OCC);
   assign occupancy  = occ;

   assign disp_hit1 = (wb_valid[0] && wb_tag0 == disp_pr1) || (wb_valid[1] && wb_tag1 == disp_pr1);
   assign disp_hit2 = (wb_valid[0] && wb_tag0 == disp_pr2) || (wb_valid[1] && wb_tag1 == disp_pr2);

   // Per-entry tag match against both writeback lanes.
   always_comb begin
      hit1 = '0;
      hit2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit1[i] = (wb_valid[0] && wb_tag0 == e_pr1[i]) || (wb_valid[1] && wb_tag1 == e_pr1[i]);
         hit2[i] = (wb_valid[1] && wb_tag1 == e_pr2[i]) || (wb_valid[0] && wb_tag0 == e_pr2[i]);
      end
   end

   // Oldest-ready select from registered ready bits; ages of valid entries are unique.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_age   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (e_valid[i] && e_rdy1[i] && e_rdy2[i] && (!sel_found || e_age[i] < sel_age)) begin
            sel_found = 1'b1;
            sel_idx   = AW'(i);
            sel_age   = e_age[i];
         end
      end
   end

   // Lowest-index free slot; scanned downward so the lowest free index wins.
   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!e_valid[i]) free_idx = AW'(i);
      end
   end

   assign iss_valid = sel_found && !flush;
   assign iss_fire  = iss_valid && iss_ready;
   assign alloc     = disp_valid && disp_ready && !flush;
   assign new_age   = AW'(occ - OW'(iss_fire));

   assign iss_opcode    = iss_valid ? e_opcode[sel_idx] : '0;
   assign iss_prd       = iss_valid ? e_prd[sel_idx]    : '0;
   assign iss_pr1       = iss_valid ? e_pr1[sel_idx]    : '0;
   assign iss_pr2       = iss_valid ? e_pr2[sel_idx]    : '0;
   assign iss_imm       = iss_valid ? e_imm[sel_idx]    : '0;
   assign iss_rob_index = iss_valid ? e_rob[sel_idx]    : '0;

   // Entry state: reset beats flush beats wakeup/issue/allocate.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_valid <= '0;
         occ     <= '0;
      end else if (flush) begin
         e_valid <= '0;
         occ     <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (e_valid[i]) begin
               if (hit1[i]) e_rdy1[i] <= 1'b1;
               if (hit2[i]) e_rdy2[i] <= 1'b1;
               if (iss_fire && e_age[i] > sel_age) e_age[i] <= e_age[i] - AW'(1);
            end
         end
         if (iss_fire) e_valid[sel_idx] <= 1'b0;
         if (alloc) begin
            e_valid[free_idx]  <= 1'b1;
            e_opcode[free_idx] <= disp_opcode;
            e_prd[free_idx]    <= disp_prd;
            e_pr1[free_idx]    <= disp_pr1;
            e_pr2[free_idx]    <= disp_pr2;
            e_imm[free_idx]    <= disp_imm;
            e_rob[free_idx]    <= disp_rob_index;
            e_rdy1[free_idx]   <= disp_pr1_ready || (disp_pr1 == '0) || disp_hit1;
            e_rdy2[free_idx]   <= disp_pr2_ready || (disp_pr2 == '0) || disp_hit2;
            e_age[free_idx]    <= new_age;
         end
         occ <= occ + OW'(alloc) - OW'(iss_fire);
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - self-checking bench for alu_rs against a dispatch-ordered queue model
module tb_alu_rs;

   localparam int DEPTH = 8;
   localparam int PRW   = 7;
   localparam int OW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             disp_valid;
   logic             disp_ready;
   logic [6:0]       disp_opcode;
   logic [PRW-1:0]   disp_prd, disp_pr1, disp_pr2;
   logic             disp_pr1_ready, disp_pr2_ready;
   logic [31:0]      disp_imm;
   logic [3:0]       disp_rob_index;
   logic [1:0]       wb_valid;
   logic [2*PRW-1:0] wb_tag;
   logic             iss_valid;
   logic             iss_ready;
   logic [6:0]       iss_opcode;
   logic [PRW-1:0]   iss_prd, iss_pr1, iss_pr2;
   logic [31:0]      iss_imm;
   logic [3:0]       iss_rob_index;
   logic             flush;
   logic [OW-1:0]    occupancy;

   int passed = 0;
   int total  = 0;
   bit chk_en = 1'b0;

   alu_rs #(.DEPTH(DEPTH), .PRW(PRW)) dut (
      .clk(clk), .reset(reset),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_opcode(disp_opcode), .disp_prd(disp_prd),
      .disp_pr1(disp_pr1), .disp_pr1_ready(disp_pr1_ready),
      .disp_pr2(disp_pr2), .disp_pr2_ready(disp_pr2_ready),
      .disp_imm(disp_imm), .disp_rob_index(disp_rob_index),
      .wb_valid(wb_valid), .wb_tag(wb_tag),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_opcode(iss_opcode), .iss_prd(iss_prd),
      .iss_pr1(iss_pr1), .iss_pr2(iss_pr2),
      .iss_imm(iss_imm), .iss_rob_index(iss_rob_index),
      .flush(flush), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]     opc;
      logic [PRW-1:0] prd, pr1, pr2;
      logic [31:0]    imm;
      logic [3:0]     rob;
      bit             r1, r2;
   } ent_t;

   // Queue in dispatch order: position equals age, so oldest-ready is the first ready element.
   ent_t mq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic bit wb_hit(input logic [PRW-1:0] t);
      return (wb_valid[0] && wb_tag[0 +: PRW] == t) || (wb_valid[1] && wb_tag[PRW +: PRW] == t);
   endfunction

   function automatic int model_sel();
      foreach (mq[i]) if (mq[i].r1 && mq[i].r2) return i;
      return -1;
   endfunction

   // Reference model update at each rising edge, from the inputs as sampled there.
   initial begin
      int   sel;
      int   n;
      ent_t e;
      forever begin
         @(posedge clk);
         if (reset || flush) begin
            mq.delete();
         end else begin
            sel = model_sel();
            n   = mq.size();
            foreach (mq[i]) begin
               if (wb_hit(mq[i].pr1)) mq[i].r1 = 1'b1;
               if (wb_hit(mq[i].pr2)) mq[i].r2 = 1'b1;
            end
            if (sel >= 0 && iss_ready) mq.delete(sel);
            if (disp_valid && n < DEPTH) begin
               e.opc = disp_opcode; e.prd = disp_prd; e.pr1 = disp_pr1; e.pr2 = disp_pr2;
               e.imm = disp_imm;    e.rob = disp_rob_index;
               e.r1  = disp_pr1_ready || disp_pr1 == 0 || wb_hit(disp_pr1);
               e.r2  = disp_pr2_ready || disp_pr2 == 0 || wb_hit(disp_pr2);
               mq.push_back(e);
            end
         end
      end
   end

   // Compare every output against the model on the falling edge.
   initial begin
      int   sel;
      ent_t e;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            sel = flush ? -1 : model_sel();
            check("occupancy", 32'(occupancy), 32'(mq.size()));
            check("disp_ready", 32'(disp_ready), 32'(mq.size() < DEPTH));
            check("iss_valid", 32'(iss_valid), 32'(sel >= 0));
            if (sel >= 0) begin
               e = mq[sel];
               check("iss_payload", {iss_opcode, iss_prd, iss_rob_index}, {e.opc, e.prd, e.rob});
               check("iss_srcs", {iss_pr1, iss_pr2}, {e.pr1, e.pr2});
               check("iss_imm", iss_imm, e.imm);
            end else begin
               check("iss_zero", {iss_opcode, iss_prd, iss_pr1, iss_pr2, iss_rob_index} | iss_imm, 32'd0);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      disp_valid = 0; disp_opcode = 0; disp_prd = 0; disp_pr1 = 0; disp_pr2 = 0;
      disp_pr1_ready = 0; disp_pr2_ready = 0; disp_imm = 0; disp_rob_index = 0;
      wb_valid = 0; wb_tag = 0; flush = 0;
   endtask

   task automatic disp(input int prd, input int pr1, input bit r1, input int pr2, input bit r2, input int rob);
      disp_valid = 1; disp_opcode = 7'(prd + 7'h20); disp_prd = PRW'(prd);
      disp_pr1 = PRW'(pr1); disp_pr1_ready = r1; disp_pr2 = PRW'(pr2); disp_pr2_ready = r2;
      disp_imm = 32'hA000_0000 + 32'(prd); disp_rob_index = 4'(rob);
   endtask

   initial begin
      reset = 1; iss_ready = 0; idle();
      tick(); tick();
      reset = 0; chk_en = 1;
      check("rst_occ", 32'(occupancy), 0);
      check("rst_disp_ready", 32'(disp_ready), 1);
      check("rst_iss_valid", 32'(iss_valid), 0);

      // Tag-0 sources are ready immediately.
      disp(5, 0, 0, 0, 0, 3); tick(); idle();
      check("t034_valid", 32'(iss_valid), 1);
      check("t034_prd", 32'(iss_prd), 5);
      check("t034_rob", 32'(iss_rob_index), 3);
      iss_ready = 1; tick(); iss_ready = 0;
      check("t034_occ", 32'(occupancy), 0);

      // Younger ready op bypasses older blocked op; wakeup visible only after the edge.
      disp(1, 10, 0, 0, 0, 1); tick();
      disp(2, 3, 1, 4, 1, 2); tick(); idle();
      check("t035_b_first", 32'(iss_prd), 2);
      iss_ready = 1; tick();
      check("t035_occ", 32'(occupancy), 1);
      wb_valid = 2'b01; wb_tag = {PRW'(0), PRW'(10)};
      check("t035_no_comb", 32'(iss_valid), 0);
      tick(); idle();
      check("t035_wake_valid", 32'(iss_valid), 1);
      check("t035_wake_prd", 32'(iss_prd), 1);
      tick(); iss_ready = 0;
      check("t035_empty", 32'(occupancy), 0);

      // Fill to full, drop the extra dispatch, drain in dispatch order.
      for (int k = 0; k < DEPTH; k++) begin disp(k + 1, 0, 0, 0, 0, k); tick(); end
      check("t036_full_ready", 32'(disp_ready), 0);
      check("t036_full_occ", 32'(occupancy), DEPTH);
      disp(30, 0, 0, 0, 0, 15); tick(); idle();
      check("t036_drop_occ", 32'(occupancy), DEPTH);
      iss_ready = 1;
      for (int k = 0; k < DEPTH; k++) begin
         check("t036_order", 32'(iss_prd), 32'(k + 1));
         tick();
      end
      iss_ready = 0;
      check("t036_drained", 32'(occupancy), 0);

      // Same-cycle writeback on lane 1 wakes the allocating entry.
      disp(9, 0, 0, 20, 0, 6); wb_valid = 2'b10; wb_tag = {PRW'(20), PRW'(0)};
      tick(); idle();
      check("t037_bypass", 32'(iss_valid), 1);
      check("t037_prd", 32'(iss_prd), 9);
      iss_ready = 1; tick(); iss_ready = 0;

      // Flush with concurrent dispatch, then reset mid-fill.
      for (int k = 0; k < 5; k++) begin disp(k + 11, 0, 0, 0, 0, k); tick(); end
      disp(17, 0, 0, 0, 0, 7); flush = 1; tick(); idle();
      check("t038_flush_occ", 32'(occupancy), 0);
      check("t038_flush_iss", 32'(iss_valid), 0);
      for (int k = 0; k < 3; k++) begin disp(k + 21, 0, 0, 0, 0, k); tick(); end
      reset = 1; tick(); reset = 0; idle();
      check("t038_rst_occ", 32'(occupancy), 0);
      check("t038_rst_iss", 32'(iss_valid), 0);
      check("t038_rst_ready", 32'(disp_ready), 1);

      // Randomised traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         disp_valid     = ($urandom_range(0, 99) < 60);
         disp_opcode    = 7'($urandom);
         disp_prd       = PRW'($urandom_range(1, 127));
         disp_pr1       = PRW'($urandom_range(0, 15));
         disp_pr2       = PRW'($urandom_range(0, 15));
         disp_pr1_ready = ($urandom_range(0, 99) < 30);
         disp_pr2_ready = ($urandom_range(0, 99) < 30);
         disp_imm       = $urandom;
         disp_rob_index = 4'($urandom);
         wb_valid       = 2'($urandom);
         wb_tag         = {PRW'($urandom_range(0, 15)), PRW'($urandom_range(0, 15))};
         iss_ready      = ($urandom_range(0, 99) < 50);
         flush          = ($urandom_range(0, 99) == 0);
         reset          = ($urandom_range(0, 299) == 0);
         tick();
      end
      reset = 0; iss_ready = 0; idle();
      tick(); tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
